// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider (quotient -> LO, remainder -> HI).
// Signed operation is built only when SEQ_DIV_SIGNED_EN is defined; otherwise signed_mode is ignored.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on acceptance
// S_PREP | sign capture, absolute values, counter load
// S_ITER | one restoring step per cycle, WIDTH cycles
// S_FIXUP| apply signs and register results
// S_DONE | one-cycle done pulse
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] orig_q, orig_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             sign_a, sign_b;
   logic [WIDTH:0]   shifted, diff;

`ifdef SEQ_DIV_SIGNED_EN
   logic mode_q, mode_d;
`else
   logic unused_signed_mode;
   assign unused_signed_mode = signed_mode;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      orig_d      = orig_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
      mode_d      = mode_q;
      sign_a      = mode_q & quo_q[WIDTH-1];
      sign_b      = mode_q & dvs_q[WIDTH-1];
`else
      sign_a      = 1'b0;
      sign_b      = 1'b0;
`endif
      shifted     = {rem_q, quo_q[WIDTH-1]};
      diff        = shifted - {1'b0, dvs_q};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               quo_d   = dividend;
               orig_d  = dividend;
               dvs_d   = divisor;
`ifdef SEQ_DIV_SIGNED_EN
               mode_d  = signed_mode;
`endif
               busy_d  = 1'b1;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            negq_d = sign_a ^ sign_b;
            negr_d = sign_a;
            if (sign_a) quo_d = -quo_q;
            if (sign_b) dvs_d = -dvs_q;
            rem_d  = '0;
            // A zero divisor idles one extra FIXUP cycle so its latency is three edges.
            if (dvs_q == '0) begin
               cnt_d   = CW'(1);
               state_d = S_FIXUP;
            end else begin
               cnt_d   = CW'(WIDTH);
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            // Partial remainder stays below the divisor, so diff never overflows WIDTH+1 bits.
            if (!diff[WIDTH]) begin
               rem_d = diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               if (dvs_q == '0) begin
                  quotient_d  = '1;
                  remainder_d = orig_q;
                  dbz_d       = 1'b1;
               end else begin
                  quotient_d  = negq_q ? -quo_q : quo_q;
                  remainder_d = negr_q ? -rem_q : rem_q;
                  dbz_d       = 1'b0;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         orig_q      <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         mode_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         orig_q      <= orig_d;
         negq_q      <= negq_d;
         negr_q      <= negr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
         mode_q      <= mode_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32); expectations follow the SEQ_DIV_SIGNED_EN setting.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        clr, start, signed_mode;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int n_chk  = 0;
   int n_fail = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .signed_mode (signed_mode),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Called just after a rising edge; start is sampled on the next edge (edge k).
   task automatic run_div(input string tag, input logic sm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz, input int elat);
      int lat;
      int busy_cnt;
      lat = 0;
      busy_cnt = 0;
      signed_mode = sm;
      dividend = a;
      divisor = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_prep"}, 32'(busy), 32'd1);
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(elat));
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dones;
      clr = 1'b1;
      start = 1'b0;
      signed_mode = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      clr = 1'b0;
      @(posedge clk); #1;

      run_div("u11_4", 1'b0, 32'h0000000B, 32'h00000004, 32'h00000002, 32'h00000003, 1'b0, 34);
      run_div("dbz", 1'b0, 32'h00000018, 32'h00000000, 32'hFFFFFFFF, 32'h00000018, 1'b1, 3);
      run_div("u_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
      run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001, 1'b0, 34);
`ifdef SEQ_DIV_SIGNED_EN
      run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
      run_div("s_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34);
      run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34);
      run_div("s_dbz", 1'b1, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 3);
`else
      run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001, 1'b0, 34);
      run_div("s_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000007, 1'b0, 34);
      run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
      run_div("s_dbz", 1'b1, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 3);
`endif

      // Start re-pulsed at ITER step 5 must be ignored: 100 / 7 = 14 r 2.
      signed_mode = 1'b0;
      dividend = 32'd100;
      divisor = 32'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      dividend = 32'd55;
      divisor = 32'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (dones == 1) begin
               check("ign_quotient", quotient, 32'd14);
               check("ign_remainder", remainder, 32'd2);
               check("ign_cycle", 32'(i), 32'd27);
            end
         end
      end
      check("ign_done_count", 32'(dones), 32'd1);
      check("ign_busy_idle", 32'(busy), 32'd0);

      // Clear at ITER step 10 aborts; start held with clr is ignored.
      dividend = 32'd1000;
      divisor = 32'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      clr = 1'b1;
      start = 1'b1;
      dividend = 32'd5;
      divisor = 32'd1;
      @(posedge clk); #1;
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_done", 32'(done), 32'd0);
      check("clr_quotient", quotient, 32'd0);
      check("clr_remainder", remainder, 32'd0);
      check("clr_dbz", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;
      check("clr_start_ignored", 32'(busy), 32'd0);
      clr = 1'b0;
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("clr_no_done", 32'(dones), 32'd0);

      // Start held high: back-to-back operations with one IDLE cycle between DONE and PREP.
      dividend = 32'd9;
      divisor = 32'd2;
      start = 1'b1;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (dones == 1) begin
               check("b2b_quotient", quotient, 32'd4);
               check("b2b_remainder", remainder, 32'd1);
            end
            @(posedge clk); #1;
            check("b2b_idle_gap", 32'(busy), 32'd0);
            @(posedge clk); #1;
            check("b2b_restart", 32'(busy), 32'd1);
            i += 2;
         end
      end
      start = 1'b0;
      check("b2b_done_count", 32'(dones), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider for the Mini SRC datapath. It replaces the single-cycle DIV path in the ALU with a shift-subtract engine. The engine takes WIDTH iterations, offers a start/done handshake, selects signed or unsigned operation, and flags divide-by-zero. Quotient feeds the LO register and remainder feeds the HI register; the control unit holds the datapath in its DIV state until `done` is asserted.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥4)
- `clk`  in  1  system clock, all state updates on rising edge
- `clr`  in  1  synchronous reset, active-high
- `start`  in  1  request a division; sampled only in IDLE
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`
- `dividend`  in  WIDTH  numerator, sampled with `start`
- `divisor`  in  WIDTH  denominator, sampled with `start`
- `busy`  out  1  high from the cycle after start acceptance until the DONE cycle inclusive
- `done`  out  1  one-cycle pulse; results valid from this cycle on
- `quotient`  out  WIDTH  LO result, held until next DONE
- `remainder`  out  WIDTH  HI result, held until next DONE
- `div_by_zero`  out  1  set in DONE when divisor was 0, held with results

## Operation
- States: IDLE → PREP → ITER → FIXUP → DONE → IDLE.
- IDLE: `start`=1 latches operands and mode, then goes to PREP. `start`=0 stays in IDLE.
- PREP: records the sign of each operand when signed, replaces operands with absolute values, clears the partial remainder, and loads the counter with WIDTH.
  - Divisor of 0 goes directly to FIXUP.
  - Otherwise goes to ITER.
- ITER: one restoring step per cycle. Shift {rem, quo} left by 1, bringing in the dividend MSB. Trial-subtract the divisor in WIDTH+1 bits. If the difference is ≥0, keep it and set quo LSB=1. Decrement the counter; at 0, go to FIXUP.
- FIXUP: applies signs and registers the outputs, then goes to DONE.
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - Quotient truncates toward zero.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Divide-by-zero result: `quotient` = all ones, `remainder` = original dividend (unmodified), `div_by_zero`=1.
- Signed overflow (most-negative / −1): `quotient` = most-negative value (wraps), `remainder` = 0, `div_by_zero`=0.
- `start` asserted outside IDLE is ignored, with no queueing.
- Outputs are never partially updated; `quotient`/`remainder`/`div_by_zero` change only on the edge entering DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter 0.
- Start sampled at edge k → PREP. Edge k+1 → ITER. Edges k+2…k+WIDTH+1 perform the WIDTH steps. Edge k+WIDTH+2 enters DONE.
- `done` is high between edges k+WIDTH+2 and k+WIDTH+3. Latency is WIDTH+2 edges (34 for WIDTH=32).
- Divide-by-zero latency: DONE is entered at edge k+3 (PREP→FIXUP→DONE).
- Earliest next start: sampled at the edge leaving DONE+1, i.e. the first IDLE cycle. `start` held high continuously gives back-to-back operations with one IDLE cycle between them.
- `clr` has priority over everything.
  - Asserted mid-operation, it aborts, and the next cycle is IDLE with all outputs at reset values.
  - `start` during `clr` is ignored.

## Configuration
- `SEQ_DIV_SIGNED_EN` defined: signed path built (sign capture, abs, FIXUP negation); `signed_mode` honoured.
- Undefined: `signed_mode` ignored; all operands are unsigned and FIXUP only registers results. Latency is unchanged.

## Test plan
- Unsigned 0x0000000B / 0x00000004, WIDTH=32:
  - `done` at edge k+34 with `quotient`=0x00000002, `remainder`=0x00000003, `div_by_zero`=0.
  - `busy` high for 34 cycles.
- Signed −7 / 2: `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. Signed 7 / −2: `quotient`=0xFFFFFFFD, `remainder`=0x00000001.
- Divisor 0 with dividend 0x00000018: `done` at edge k+3, `quotient`=0xFFFFFFFF, `remainder`=0x00000018, `div_by_zero`=1.
- Signed 0x80000000 / 0xFFFFFFFF: `quotient`=0x80000000, `remainder`=0. The same operands unsigned give `quotient`=0, `remainder`=0x80000000.
- `start` pulsed again at ITER step 5 with new operands: ignored, and the original result is delivered. `clr` at ITER step 10: next cycle IDLE, all outputs 0, no `done` pulse.
- Build without `SEQ_DIV_SIGNED_EN`, with `signed_mode`=1 and 0xFFFFFFF9 / 2: `quotient`=0x7FFFFFFC, `remainder`=1.
